// File: rtl/sync_fifo_fwft_lvl_pkg.sv
// Shared definitions for the FWFT level FIFO: depth helper and the registered
// status-flag bundle with its power-on/flush value.
package sync_fifo_fwft_lvl_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};

endpackage

// File: rtl/sync_fifo_fwft_lvl_sdp_ram_reg.sv
// Simple dual-port RAM with registered, enable-gated read; the read register
// holds its value between reads so it can serve directly as the FIFO head.
module sdp_ram_reg #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft_lvl.sv
// Single-clock first-word-fall-through FIFO with fill level, programmable
// almost flags, guarded push/pop, sticky error flags and synchronous flush.
module sync_fifo_fwft_lvl
  import sync_fifo_fwft_lvl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int AF_DEFAULT = fifo_depth(ADDR_WIDTH) - 4,
  parameter int AE_DEFAULT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  input  logic                  thr_wr_i,
  input  logic [ADDR_WIDTH:0]   af_thr_i,
  input  logic [ADDR_WIDTH:0]   ae_thr_i,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int LW    = ADDR_WIDTH + 1;

  typedef logic [LW-1:0] lvl_t;

  // rd_ptr counts words moved from RAM into the output stage, not words popped.
  lvl_t        wr_ptr_q, wr_ptr_d;
  lvl_t        rd_ptr_q, rd_ptr_d;
  lvl_t        level_q, level_d;
  lvl_t        af_thr_q, af_thr_d;
  lvl_t        ae_thr_q, ae_thr_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  fifo_flags_t flags_q, flags_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic                  ram_has;
  logic                  prefetch;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    push_ok  = wr_en_i && !flags_q.full && !flush_i;
    pop_ok   = rd_en_i && valid_q && !flush_i;
    ram_has  = (wr_ptr_q != rd_ptr_q);
    prefetch = ram_has && (!valid_q || pop_ok) && !flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    flags_d  = flags_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    af_thr_d = thr_wr_i ? af_thr_i : af_thr_q;
    ae_thr_d = thr_wr_i ? ae_thr_i : ae_thr_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      flags_d  = FLAGS_RESET;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + lvl_t'(1);
      end
      if (prefetch) begin
        rd_ptr_d = rd_ptr_q + lvl_t'(1);
        valid_d  = 1'b1;
      end else if (pop_ok) begin
        valid_d  = 1'b0;
      end
      level_d              = level_q + lvl_t'(push_ok) - lvl_t'(pop_ok);
      flags_d.full         = (level_d == lvl_t'(DEPTH));
      flags_d.almost_full  = (level_d >= af_thr_q);
      flags_d.almost_empty = (level_d <= ae_thr_q);
      ovf_d                = ovf_q | (wr_en_i && flags_q.full);
      udf_d                = udf_q | (rd_en_i && !valid_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      flags_q  <= FLAGS_RESET;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      af_thr_q <= lvl_t'(AF_DEFAULT);
      ae_thr_q <= lvl_t'(AE_DEFAULT);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      af_thr_q <= af_thr_d;
      ae_thr_q <= ae_thr_d;
    end
  end

  // The RAM read register is the head word; it is masked while no head is held.
  sdp_ram_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (prefetch),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign rd_data_o      = valid_q ? ram_rdata : '0;
  assign empty_o        = !valid_q;
  assign full_o         = flags_q.full;
  assign almost_full_o  = flags_q.almost_full;
  assign almost_empty_o = flags_q.almost_empty;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft_lvl.sv
// Randomised scoreboard bench for sync_fifo_fwft_lvl at ADDR_WIDTH=4: a word
// queue models the contents, a monitor checks every popped word.
module tb_sync_fifo_fwft_lvl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_en_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [LW-1:0] level_o;
  logic          thr_wr_i = 1'b0;
  logic [LW-1:0] af_thr_i = '0;
  logic [LW-1:0] ae_thr_i = '0;
  logic          overflow_o, underflow_o;

  always #5 clk = ~clk;

  sync_fifo_fwft_lvl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .rd_en_i        (rd_en_i),
    .rd_data_o      (rd_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .level_o        (level_o),
    .thr_wr_i       (thr_wr_i),
    .af_thr_i       (af_thr_i),
    .ae_thr_i       (ae_thr_i),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents queue plus a few scalar facts about the FIFO.
  logic [DW-1:0] sb_q[$];
  int  m_level = 0;
  bit  m_vis = 0;
  bit  m_ovf = 0, m_udf = 0;
  bit  m_full = 0, m_afl = 0, m_ael = 1;
  int  m_af_thr = DEPTH - 4;
  int  m_ae_thr = 4;
  bit  after_reset = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge; its word must be the oldest one.
  always @(negedge clk) begin
    if (!reset && !flush_i && rd_en_i && !empty_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got %0h expected no word (t=%0t)", rd_data_o, $time);
      end else begin
        chk("pop_data", rd_data_o, sb_q[0]);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input bit rst, input bit fl, input bit wr, input logic [DW-1:0] wd,
                      input bit rd, input bit thr, input int af, input int ae);
    bit push_ok, pop_ok;
    reset     = rst;
    flush_i   = fl;
    wr_en_i   = wr;
    wr_data_i = wd;
    rd_en_i   = rd;
    thr_wr_i  = thr;
    af_thr_i  = LW'(af);
    ae_thr_i  = LW'(ae);
    @(posedge clk);
    #1;
    after_reset = rst;
    if (rst) begin
      m_level = 0; m_vis = 0; m_ovf = 0; m_udf = 0;
      m_full = 0; m_afl = 0; m_ael = 1;
      m_af_thr = DEPTH - 4; m_ae_thr = 4;
      sb_q.delete();
    end else if (fl) begin
      m_level = 0; m_vis = 0; m_full = 0; m_afl = 0; m_ael = 1;
      sb_q.delete();
      if (thr) begin m_af_thr = af; m_ae_thr = ae; end
    end else begin
      push_ok = wr && (m_level != DEPTH);
      pop_ok  = rd && m_vis;
      if (wr && !push_ok) m_ovf = 1;
      if (rd && !pop_ok)  m_udf = 1;
      // A stored word becomes visible one edge after it was written.
      m_vis = (m_level - int'(pop_ok)) > 0;
      if (push_ok) sb_q.push_back(wd);
      m_level = m_level + int'(push_ok) - int'(pop_ok);
      m_full = (m_level == DEPTH);
      m_afl  = (m_level >= m_af_thr);
      m_ael  = (m_level <= m_ae_thr);
      if (thr) begin m_af_thr = af; m_ae_thr = ae; end
    end
    chk("level", 32'(level_o), 32'(m_level));
    chk("empty", 32'(empty_o), 32'(!m_vis));
    chk("full", 32'(full_o), 32'(m_full));
    chk("almost_full", 32'(almost_full_o), 32'(m_afl));
    chk("almost_empty", 32'(almost_empty_o), 32'(m_ael));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("underflow", 32'(underflow_o), 32'(m_udf));
    if (m_vis && sb_q.size() > 0) chk("head_data", 32'(rd_data_o), 32'(sb_q[0]));
    else if (after_reset)         chk("reset_data", 32'(rd_data_o), 32'h0);
  endtask

  task automatic idle();    step(0, 0, 0, '0, 0, 0, 0, 0); endtask
  task automatic do_rst();  step(1, 0, 0, '0, 0, 0, 0, 0); endtask
  task automatic push(input logic [DW-1:0] d); step(0, 0, 1, d, 0, 0, 0, 0); endtask
  task automatic pop();     step(0, 0, 0, '0, 1, 0, 0, 0); endtask

  initial begin
    do_rst();
    do_rst();
    // First-word fall-through latency
    push(16'hA5A5);
    idle();
    pop();
    idle();

    // Fill to full, overflow, push+pop at full, drain in order
    do_rst();
    for (int i = 0; i < DEPTH; i++) push(DW'(i));
    push(16'h0099);
    step(0, 0, 1, 16'h0077, 1, 0, 0, 0);
    while (m_level > 0) pop();
    // Push+pop on an empty FIFO
    do_rst();
    step(0, 0, 1, 16'h1234, 1, 0, 0, 0);
    idle();
    pop();

    // Streaming at level 8 across several pointer wraps
    do_rst();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, 1, DW'($urandom), 1, 0, 0, 0);
    while (m_level > 0) pop();

    // Threshold reprogramming: af=10, ae=2
    do_rst();
    step(0, 0, 0, '0, 0, 1, 10, 2);
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    while (m_level > 0) pop();

    // Flush at level 7 with a concurrent push; error flags survive
    do_rst();
    pop();
    for (int i = 0; i < 7; i++) push(DW'($urandom));
    step(0, 1, 1, 16'hBEEF, 1, 0, 0, 0);
    idle();
    push(16'h5555);
    idle();

    // Randomised traffic with occasional flush, threshold writes and reset
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = (i < 1500) ? 70 : 40;
      rp = (i < 1500) ? 40 : 70;
      step(($urandom_range(0, 999) < 2), ($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 99) < 2), $urandom_range(0, DEPTH), $urandom_range(0, DEPTH));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
